// File: rtl/apb_regbank_pkg.sv
// apb_regbank_pkg: shared types and helpers for the APB register bank.
// Optional wait states are enabled with the APB_REGBANK_WAIT_EN macro (see apb_regbank.sv).
package apb_regbank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FN_W    = 32;
    localparam int unsigned MAX_STRB = 4;

    // Word index from a byte address for the given data width.
    function automatic logic [FN_W-1:0] addr_to_idx(input logic [FN_W-1:0] paddr,
                                                    input int unsigned     data_w);
        logic [FN_W-1:0] idx;
        case (data_w)
            32:      idx = paddr >> 2;
            16:      idx = paddr >> 1;
            default: idx = paddr;
        endcase
        return idx;
    endfunction

    // Expand byte strobes into a per-bit enable mask.
    function automatic logic [FN_W-1:0] strb_to_bitmask(input logic [MAX_STRB-1:0] pwstrb);
        logic [FN_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < int'(MAX_STRB); b++) begin
            mask[b*8 +: 8] = {8{pwstrb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// apb_regbank_if: APB4 bus bundle between requester and the register bank.
interface apb_regbank_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic [2:0]          pprot;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pwstrb;
    logic                pwakeup;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pwstrb, pwakeup,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pwstrb, pwakeup,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_regbank_reg.sv
// apb_regbank_reg: one register with writable-bit mask, byte-strobe write and write pulse.
module apb_regbank_reg #(
    parameter int unsigned         DATA_W  = 32,
    parameter logic [DATA_W-1:0]   WR_MASK = '1,
    parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bitmask,
    output logic [DATA_W-1:0] q,
    output logic              pulse
);

    logic [DATA_W-1:0] upd_c;

    // Only bits both writable and strobed take the new data.
    assign upd_c = WR_MASK & bitmask;

    // Register contents and the one-cycle commit pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q     <= RST_VAL;
            pulse <= 1'b0;
        end else begin
            pulse <= we;
            if (we) begin
                q <= (q & ~upd_c) | (wdata & upd_c);
            end
        end
    end

endmodule

// File: rtl/apb_regbank.sv
// apb_regbank: APB4 completer register bank with masks, strobes, privilege and error response.
// Define APB_REGBANK_WAIT_EN to implement the WAIT_CYCLES access-phase wait counter.
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int unsigned                  ADDR_W      = 12,
    parameter int unsigned                  DATA_W      = 32,
    parameter int unsigned                  NUM_REGS    = 4,
    parameter logic [NUM_REGS*DATA_W-1:0]   WR_MASK     = '1,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL     = '0,
    parameter logic [NUM_REGS-1:0]          PRIV_MASK   = '0,
    parameter int unsigned                  WAIT_CYCLES = 0
) (
    input  logic                         pclk,
    input  logic                         presetn,
    apb_regbank_if.slave                 bus,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned PRIV_EXT_W = 1 << IDX_W;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                commit_c;
    logic                pready_c;
    logic                pslverr_c;
    logic [DATA_W-1:0]   prdata_c;

    logic [FN_W-1:0]       idx_full;
    logic                  misaligned;
    logic                  out_of_range;
    logic [PRIV_EXT_W-1:0] priv_ext;
    logic                  setup_err;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     wr_bitmask;
    logic                  unused_prot;

    // Setup-phase address decode and error classification.
    assign idx_full     = addr_to_idx(FN_W'(bus.paddr), DATA_W);
    assign misaligned   = (FN_W'(bus.paddr) & FN_W'(STRB_W - 1)) != '0;
    assign out_of_range = idx_full >= FN_W'(NUM_REGS);
    assign priv_ext     = PRIV_EXT_W'(PRIV_MASK);
    assign setup_err    = out_of_range | misaligned | !bus.pwakeup |
                          (bus.pwrite & priv_ext[idx_full[IDX_W-1:0]] & !bus.pprot[0]);
    assign unused_prot  = ^bus.pprot[2:1];

    assign rd_word    = reg_q[idx_q*DATA_W +: DATA_W];
    assign wr_bitmask = DATA_W'(strb_to_bitmask(MAX_STRB'(bus.pwstrb)));

    // State, captured index/error.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

`ifdef APB_REGBANK_WAIT_EN
    // Access-phase wait counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cnt;
    // Counter absent: every transfer is zero-wait.
    assign cnt_q      = '0;
    assign unused_cnt = ^cnt_d;
`endif

    // Next-state, counter, commit and bus response.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        commit_c  = 1'b0;
        pready_c  = 1'b0;
        pslverr_c = 1'b0;
        prdata_c  = '0;
        case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_d = ACCESS;
                    idx_d   = idx_full[IDX_W-1:0];
                    err_d   = setup_err;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                pready_c = bus.psel && bus.penable && (cnt_q == '0);
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (pready_c) begin
                    state_d   = IDLE;
                    commit_c  = bus.pwrite && !err_q;
                    pslverr_c = err_q;
                    if (!bus.pwrite && !err_q) begin
                        prdata_c = rd_word;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pready  = pready_c;
    assign bus.pslverr = pslverr_c;
    assign bus.prdata  = prdata_c;

    // Register cells.
    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
        apb_regbank_reg #(
            .DATA_W  (DATA_W),
            .WR_MASK (WR_MASK[i*DATA_W +: DATA_W]),
            .RST_VAL (RST_VAL[i*DATA_W +: DATA_W])
        ) u_reg (
            .clk     (pclk),
            .resetn  (presetn),
            .we      (commit_c && (idx_q == IDX_W'(i))),
            .wdata   (bus.pwdata),
            .bitmask (wr_bitmask),
            .q       (reg_q[i*DATA_W +: DATA_W]),
            .pulse   (wr_pulse[i])
        );
    end

endmodule

// File: tb/tb_apb_regbank.sv
// tb_apb_regbank: directed self-checking bench for apb_regbank.
module tb_apb_regbank;

    localparam logic [127:0] WR_MASK_P  = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF};
    localparam logic [127:0] RST_VAL_P  = {32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [3:0]   PRIV_P     = 4'b0100;
`ifdef APB_REGBANK_WAIT_EN
    localparam int           LAT_EXP    = 4;
`else
    localparam int           LAT_EXP    = 1;
`endif

    logic         pclk;
    logic         presetn;
    logic [127:0] reg_q;
    logic [3:0]   wr_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    apb_regbank_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    apb_regbank #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .NUM_REGS    (4),
        .WR_MASK     (WR_MASK_P),
        .RST_VAL     (RST_VAL_P),
        .PRIV_MASK   (PRIV_P),
        .WAIT_CYCLES (3)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .bus      (bus),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; called #1 after a clock edge, returns #1 after the completion edge.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input logic wake,
                        output logic [31:0] rdata, output logic err, output logic [3:0] pulse);
        int lat;
        bus.paddr   = addr;
        bus.pwrite  = wr;
        bus.pwdata  = data;
        bus.pwstrb  = strb;
        bus.pprot   = prot;
        bus.pwakeup = wake;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(posedge pclk);
        #1 bus.penable = 1'b1;
        #1;
        lat = 1;
        while (bus.pready !== 1'b1 && lat < 20) begin
            @(posedge pclk);
            #2;
            lat++;
        end
        check("latency", 128'(lat), 128'(LAT_EXP));
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge pclk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwakeup = 1'b1;
        pulse       = wr_pulse;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [3:0]  pl;

    initial begin
        presetn     = 1'b0;
        bus.paddr   = '0;
        bus.pprot   = '0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.pwdata  = '0;
        bus.pwstrb  = '0;
        bus.pwakeup = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_reg_q", reg_q, RST_VAL_P);
        check("rst_pready", 128'(bus.pready), 128'(0));
        check("rst_pslverr", 128'(bus.pslverr), 128'(0));
        check("rst_prdata", 128'(bus.prdata), 128'(0));
        check("rst_wr_pulse", 128'(wr_pulse), 128'(0));
        presetn = 1'b1;

        // Partially writable register 1.
        xfer(1'b1, 12'h004, 32'hFFFF_FFFF, 4'hF, 3'd0, 1'b1, rd, er, pl);
        check("r1_wr_err", 128'(er), 128'(0));
        check("r1_pulse", 128'(pl), 128'(4'b0010));
        @(posedge pclk); #1;
        check("r1_pulse_once", 128'(wr_pulse), 128'(0));
        check("r1_reg_q", 128'(reg_q[63:32]), 128'(32'hFFFF_0000));
        xfer(1'b0, 12'h004, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("r1_rd", 128'(rd), 128'(32'hFFFF_0000));
        check("r1_rd_err", 128'(er), 128'(0));

        // Byte strobes on register 0.
        xfer(1'b1, 12'h000, 32'hAAAA_AAAA, 4'hF, 3'd0, 1'b1, rd, er, pl);
        xfer(1'b1, 12'h000, 32'h5555_5555, 4'b0011, 3'd0, 1'b1, rd, er, pl);
        xfer(1'b0, 12'h000, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("strb_rd", 128'(rd), 128'(32'hAAAA_5555));

        // Zero-strobe write: no change, no error, pulse still raised.
        xfer(1'b1, 12'h000, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("zstrb_err", 128'(er), 128'(0));
        check("zstrb_pulse", 128'(pl), 128'(4'b0001));
        check("zstrb_reg", 128'(reg_q[31:0]), 128'(32'hAAAA_5555));

        // Out-of-range and misaligned accesses.
        xfer(1'b0, 12'h100, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("oor_rd_err", 128'(er), 128'(1));
        check("oor_rd_data", 128'(rd), 128'(0));
        xfer(1'b1, 12'h100, 32'h1234_5678, 4'hF, 3'd0, 1'b1, rd, er, pl);
        check("oor_wr_err", 128'(er), 128'(1));
        check("oor_wr_pulse", 128'(pl), 128'(0));
        check("oor_wr_regs", reg_q, {32'hDEAD_BEEF, 32'h0, 32'hFFFF_0000, 32'hAAAA_5555});
        xfer(1'b1, 12'h002, 32'h0, 4'hF, 3'd0, 1'b1, rd, er, pl);
        check("mis_wr_err", 128'(er), 128'(1));
        check("mis_wr_pulse", 128'(pl), 128'(0));
        check("mis_wr_reg", 128'(reg_q[31:0]), 128'(32'hAAAA_5555));
        xfer(1'b0, 12'h002, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("mis_rd_err", 128'(er), 128'(1));
        check("mis_rd_data", 128'(rd), 128'(0));

        // Privileged register 2.
        xfer(1'b1, 12'h008, 32'h0000_0011, 4'hF, 3'd0, 1'b1, rd, er, pl);
        check("priv0_err", 128'(er), 128'(1));
        check("priv0_pulse", 128'(pl), 128'(0));
        check("priv0_reg", 128'(reg_q[95:64]), 128'(0));
        xfer(1'b1, 12'h008, 32'h0000_0011, 4'hF, 3'd1, 1'b1, rd, er, pl);
        check("priv1_err", 128'(er), 128'(0));
        check("priv1_pulse", 128'(pl), 128'(4'b0100));
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("priv_rd", 128'(rd), 128'(32'h0000_0011));
        check("priv_rd_err", 128'(er), 128'(0));

        // No wakeup.
        xfer(1'b0, 12'h000, 32'h0, 4'h0, 3'd0, 1'b0, rd, er, pl);
        check("wake_err", 128'(er), 128'(1));
        check("wake_data", 128'(rd), 128'(0));

        // Back-to-back write then read.
        xfer(1'b1, 12'h00C, 32'hCAFE_F00D, 4'hF, 3'd0, 1'b1, rd, er, pl);
        check("b2b_pulse", 128'(pl), 128'(4'b1000));
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("b2b_rd", 128'(rd), 128'(32'hCAFE_F00D));

        // Abort: psel drops in the access phase.
        bus.paddr   = 12'h00C;
        bus.pwrite  = 1'b1;
        bus.pwdata  = 32'h0;
        bus.pwstrb  = 4'hF;
        bus.pprot   = 3'd0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(posedge pclk);
        #1 bus.psel = 1'b0;
        bus.penable = 1'b1;
        @(posedge pclk);
        #1 bus.penable = 1'b0;
        check("abort_pulse", 128'(wr_pulse), 128'(0));
        check("abort_reg", 128'(reg_q[127:96]), 128'(32'hCAFE_F00D));
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("abort_rd", 128'(rd), 128'(32'hCAFE_F00D));

        // Reset in the middle of an access phase.
        bus.paddr   = 12'h000;
        bus.pwrite  = 1'b1;
        bus.pwdata  = 32'h1111_1111;
        bus.pwstrb  = 4'hF;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(posedge pclk);
        #1 bus.penable = 1'b1;
        #1 presetn = 1'b0;
        #1;
        check("mid_rst_pready", 128'(bus.pready), 128'(0));
        check("mid_rst_pslverr", 128'(bus.pslverr), 128'(0));
        check("mid_rst_reg_q", reg_q, RST_VAL_P);
        check("mid_rst_pulse", 128'(wr_pulse), 128'(0));
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(posedge pclk);
        #1 presetn = 1'b1;
        xfer(1'b0, 12'h000, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("post_rst_r0", 128'(rd), 128'(0));
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'd0, 1'b1, rd, er, pl);
        check("post_rst_r3", 128'(rd), 128'(32'hDEAD_BEEF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_regbank.md
# apb_regbank

Parametrised APB4 completer register bank: NUM_REGS registers of DATA_W bits each, with per-register writable-bit masks, byte strobes, privilege protection, error response, and optional wait-state insertion. It sits directly on the APB bus as the DUT behind the bench APB interface. It exposes register contents and per-register write pulses to core logic.

## Interface
- ADDR_W, 12: paddr width (byte address).
- DATA_W, 32: data width; 8, 16 or 32.
- NUM_REGS, 4: number of registers; 1..64.
- WR_MASK, all ones: NUM_REGS*DATA_W packed; a 1 marks a writable bit. Register i occupies slice [i*DATA_W +: DATA_W].
- RST_VAL, all zeros: NUM_REGS*DATA_W packed reset values.
- PRIV_MASK, 0: NUM_REGS bits; a 1 marks a register that is writable only with pprot[0]=1.
- WAIT_CYCLES, 0: access-phase wait states, 0..15. Honoured only with APB_REGBANK_WAIT_EN.

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous, active-low reset.
- paddr  in  ADDR_W  byte address.
- pprot  in  3  protection; only bit 0 (privileged) is used.
- psel, penable, pwrite  in  1 each  APB control.
- pwdata  in  DATA_W  write data.
- pwstrb  in  DATA_W/8  write byte strobes.
- pready  out  1  transfer complete.
- prdata  out  DATA_W  read data.
- pslverr  out  1  error response.
- pwakeup  in  1  requester wake indication.
- reg_q  out  NUM_REGS*DATA_W  current register contents.
- wr_pulse  out  NUM_REGS  one-cycle pulse per committed write.

## Operation
- States are IDLE and ACCESS.
- IDLE → ACCESS on psel=1, penable=0 (setup phase). At that edge the block captures:
  - idx = paddr >> log2(DATA_W/8).
  - err = (idx ≥ NUM_REGS) | misaligned paddr | !pwakeup | (pwrite & PRIV_MASK[idx] & !pprot[0]).
  - The wait counter is loaded with WAIT_CYCLES.
- In ACCESS, the counter decrements each cycle while nonzero. pready = (state==ACCESS) & psel & penable & (cnt==0).
- Completion edge (pready=1): ACCESS → IDLE.
- Write commit happens on the completion edge, only when err=0. For each byte b with pwstrb[b]=1: reg[idx] = (reg & ~WR_MASK) | (pwdata & WR_MASK). Masked and unstrobed bits are unchanged.
  - A write with pwstrb=0 completes normally with no change and no error.
- Reads ignore pwstrb. prdata = reg[idx] when pready & !pwrite & !err, else 0.
- pslverr = pready & err. An errored write changes nothing and raises no wr_pulse. An errored read returns prdata=0.
- wr_pulse[idx] is 1 for exactly the cycle after a committed write, including pwstrb=0 writes without error.
- Abort: psel=0 while in ACCESS → IDLE, no write, no pulse.
- Reset, including mid-transfer: state=IDLE, cnt=0, registers=RST_VAL, pready=0, prdata=0, pslverr=0, wr_pulse=0.

## Timing
- Setup at edge T; the access phase starts at T+1; pready is high during cycle T+1+WAIT_CYCLES.
- Zero-wait configuration: a 2-cycle transfer.
- Register update is visible on reg_q, and to a read, from the cycle after the commit edge. A back-to-back write then read returns the new value.
- pready, prdata and pslverr are combinational from state, cnt, psel and penable. No other combinational paths from paddr or pwdata reach outputs.

## Configuration
- APB_REGBANK_WAIT_EN defined: wait counter of 4 bits implemented; WAIT_CYCLES honoured.
- Undefined: no counter; cnt is constant 0; WAIT_CYCLES ignored; every transfer is zero-wait.

## Structure
- apb_regbank_pkg holds:
  - the state enum (IDLE, ACCESS);
  - function addr_to_idx(paddr, DATA_W);
  - function strb_to_bitmask(pwstrb).
- Sub-module apb_regbank_reg: one register cell with strobe/mask write, reset value and write pulse, instantiated NUM_REGS times in a generate loop.

## Test plan
- Reset: presetn low mid-ACCESS → pready=0, pslverr=0, reg_q=RST_VAL, state IDLE.
- WR_MASK[1]=0xFFFF0000: write reg 1 with 0xFFFFFFFF → read returns 0xFFFF0000; wr_pulse[1] pulses once.
- Write 0xAAAAAAAA then 0x55555555 to reg 0 with pwstrb=4'b0011 → read returns 0xAAAA5555.
- paddr=0x100 with NUM_REGS=4, and paddr=0x2 → pslverr=1, prdata=0, no register change.
- PRIV_MASK[2]=1: write with pprot=0 → pslverr=1; with pprot=1 → write commits. Also pwakeup=0 → pslverr=1.
- WAIT_EN with WAIT_CYCLES=3 → pready rises exactly 4 cycles after setup. Without WAIT_EN → 1 cycle after setup.
